// File: rtl/workout_timer_if.sv
// =============================================================================
// workout_timer_if : control/status bundle between workout FSM and timer
// Revision: 1.0
// =============================================================================
`default_nettype none

interface workout_timer_if;
  logic       start_timer;
  logic [1:0] state_in;
  logic       skip;
  logic [7:0] work_sec;
  logic [7:0] rest_sec;
  logic       time_done;
  logic [7:0] remaining;
  logic [3:0] min_digit;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       warn;

  modport master (
    output start_timer, state_in, skip, work_sec, rest_sec,
    input  time_done, remaining, min_digit, sec_tens, sec_ones, running, warn
  );

  modport slave (
    input  start_timer, state_in, skip, work_sec, rest_sec,
    output time_done, remaining, min_digit, sec_tens, sec_ones, running, warn
  );
endinterface

`default_nettype wire

// File: rtl/workout_timer.sv
// =============================================================================
// workout_timer : 1 Hz interval countdown with m:ss BCD display.
// Optional macro TIMER_WARN_EN enables the final-seconds warn output.
// Revision: 1.0
// =============================================================================
`default_nettype none

module workout_timer #(
  parameter int MIN_SEC  = 1,
  parameter int WARN_SEC = 3
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  workout_timer_if.slave   tif
);

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_EXPIRE = 2'd2
  } state_t;

  localparam logic [1:0] PH_WORKOUT = 2'b01;
  localparam logic [1:0] PH_REST    = 2'b10;
  localparam logic [7:0] MIN_LOAD   = 8'(MIN_SEC);

  state_t     state, state_nxt;
  logic [7:0] count, count_nxt;
  logic [1:0] prev_state;
  logic       time_done_q, time_done_nxt;

  logic [7:0] sel_sec;
  logic [7:0] load_val;
  logic       phase_active;

  assign phase_active = (tif.state_in == PH_WORKOUT) || (tif.state_in == PH_REST);
  assign sel_sec      = (tif.state_in == PH_REST) ? tif.rest_sec : tif.work_sec;
  assign load_val     = (sel_sec == 8'd0) ? MIN_LOAD : sel_sec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_STOP;
      count       <= 8'd0;
      prev_state  <= 2'b00;
      time_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      prev_state  <= tif.state_in;
      time_done_q <= time_done_nxt;
    end
  end

  // Priority: start low, then skip, then phase-change reload, then countdown.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    time_done_nxt = 1'b0;
    if (!tif.start_timer) begin
      state_nxt = ST_STOP;
      count_nxt = 8'd0;
    end else begin
      case (state)
        ST_STOP: begin
          if (phase_active) begin
            state_nxt = ST_RUN;
            count_nxt = load_val;
          end
        end
        ST_RUN: begin
          if (tif.skip && (tif.state_in == PH_WORKOUT)) begin
            state_nxt = ST_STOP;
            count_nxt = 8'd0;
          end else if (tif.state_in != prev_state) begin
            count_nxt = load_val;
          end else if (count <= 8'd1) begin
            // count==0 cannot occur in RUN; folding it here keeps the counter from wrapping
            state_nxt     = ST_EXPIRE;
            count_nxt     = 8'd0;
            time_done_nxt = 1'b1;
          end else begin
            count_nxt = count - 8'd1;
          end
        end
        ST_EXPIRE: begin
          state_nxt = ST_STOP;
          count_nxt = 8'd0;
        end
        default: begin
          state_nxt = ST_STOP;
          count_nxt = 8'd0;
        end
      endcase
    end
  end

  assign tif.time_done = time_done_q;
  assign tif.remaining = count;
  assign tif.running   = (state == ST_RUN);
  assign tif.min_digit = 4'(count / 8'd60);
  assign tif.sec_tens  = 4'((count % 8'd60) / 8'd10);
  assign tif.sec_ones  = 4'(count % 8'd10);

`ifdef TIMER_WARN_EN
  localparam logic [7:0] WARN_LIM = 8'(WARN_SEC);

  logic warn_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= (state_nxt == ST_RUN) && (count_nxt != 8'd0) && (count_nxt <= WARN_LIM);
    end
  end

  assign tif.warn = warn_q;
`else
  // No warning window in this build; the comparison is elaboration-constant 0.
  assign tif.warn = (WARN_SEC < 0);
`endif

endmodule

`default_nettype wire
